// File: rtl/smi_rx_pkg.sv
// Shared types and constants for the SMI receive-side scheduler.
// Holds the scheduler state encoding, channel ids and a byte-lane helper.
package smi_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULL  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SERVE = 2'd3
    } state_t;

    localparam logic CH_09 = 1'b0;
    localparam logic CH_24 = 1'b1;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

    // Byte idx of a 32-bit word counted from the MSB end (idx 0 = bits 31:24).
    function automatic logic [7:0] word_byte(input logic [31:0] word,
                                             input logic [BYTE_IDX_W-1:0] idx);
        return word[8*(BYTES_PER_WORD-1-int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/smi_strobe_sync.sv
// Two-flop synchroniser for the SMI read strobe plus a rising-edge detector.
// The strobe idles high, so every flop resets to 1 and reset never fakes an edge.
module smi_strobe_sync (
    input  logic i_clk,
    input  logic i_rst_b,
    input  logic i_strobe,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    // Resynchronise the pin and keep one cycle of history for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_meta   <= i_strobe;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/smi_rx_scheduler.sv
// Round-robin read scheduler from the two RX sample FIFOs to the SMI byte bus.
// Pulls one 32-bit word from an eligible FIFO, then serves it MSB first, one
// byte per SMI read strobe. Optional feature macro: SMI_RX_UNDERRUN_CNT_EN
// adds a saturating count of strobes that arrive with no word staged.
module smi_rx_scheduler
    import smi_rx_pkg::*;
(
    input  logic        i_sys_clk,
    input  logic        i_rst_b,
    input  logic        i_enable,
    input  logic [1:0]  i_ch_mask,
    output logic        o_fifo_09_pull,
    input  logic [31:0] i_fifo_09_pulled_data,
    input  logic        i_fifo_09_empty,
    output logic        o_fifo_24_pull,
    input  logic [31:0] i_fifo_24_pulled_data,
    input  logic        i_fifo_24_empty,
    input  logic        i_smi_soe_se,
    output logic [7:0]  o_smi_data_out,
    output logic        o_smi_read_req,
    output logic        o_active_ch,
    output logic [7:0]  o_underrun_cnt
);

    state_t                r_state;
    logic                  r_last_served;
    logic                  r_sel;
    logic [31:0]           r_staging;
    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic                  r_pull_09;
    logic                  r_pull_24;
    logic                  r_read_req;
    logic                  r_active_ch;
    logic [7:0]            r_data_out;

    logic                  w_strobe_end;
    logic                  w_elig_09;
    logic                  w_elig_24;
    logic                  w_any_elig;
    logic                  w_pick;
    logic [31:0]           w_pulled_word;
    logic [BYTE_IDX_W-1:0] w_next_idx;
    logic                  w_last_byte;

    smi_strobe_sync u_strobe_sync (
        .i_clk    (i_sys_clk),
        .i_rst_b  (i_rst_b),
        .i_strobe (i_smi_soe_se),
        .o_rise   (w_strobe_end)
    );

    assign w_elig_09  = i_ch_mask[0] & ~i_fifo_09_empty;
    assign w_elig_24  = i_ch_mask[1] & ~i_fifo_24_empty;
    assign w_any_elig = w_elig_09 | w_elig_24;

    // On a tie the channel that was not served last wins; otherwise the only eligible one.
    assign w_pick = (w_elig_09 & w_elig_24) ? ~r_last_served :
                    (w_elig_09 ? CH_09 : CH_24);

    assign w_pulled_word = (r_sel == CH_24) ? i_fifo_24_pulled_data : i_fifo_09_pulled_data;
    assign w_next_idx    = r_byte_idx + 1'b1;
    assign w_last_byte   = (r_byte_idx == BYTE_IDX_W'(BYTES_PER_WORD-1));

    // Scheduler FSM; a low enable aborts any state and discards the staged word.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_state       <= ST_IDLE;
            r_last_served <= CH_24;
            r_sel         <= CH_09;
            r_staging     <= 32'h0;
            r_byte_idx    <= '0;
            r_pull_09     <= 1'b0;
            r_pull_24     <= 1'b0;
            r_read_req    <= 1'b0;
            r_active_ch   <= 1'b0;
            r_data_out    <= 8'h00;
        end else if (!i_enable) begin
            r_state    <= ST_IDLE;
            r_staging  <= 32'h0;
            r_byte_idx <= '0;
            r_pull_09  <= 1'b0;
            r_pull_24  <= 1'b0;
            r_read_req <= 1'b0;
            r_data_out <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_elig) begin
                        r_sel     <= w_pick;
                        r_pull_09 <= (w_pick == CH_09);
                        r_pull_24 <= (w_pick == CH_24);
                        r_state   <= ST_PULL;
                    end
                end
                ST_PULL: begin
                    r_pull_09 <= 1'b0;
                    r_pull_24 <= 1'b0;
                    r_state   <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_staging     <= w_pulled_word;
                    r_byte_idx    <= '0;
                    r_active_ch   <= r_sel;
                    r_last_served <= r_sel;
                    r_read_req    <= 1'b1;
                    r_data_out    <= w_pulled_word[31:24];
                    r_state       <= ST_SERVE;
                end
                ST_SERVE: begin
                    if (w_strobe_end) begin
                        if (w_last_byte) begin
                            r_byte_idx <= '0;
                            r_read_req <= 1'b0;
                            r_data_out <= 8'h00;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_byte_idx <= w_next_idx;
                            r_data_out <= word_byte(r_staging, w_next_idx);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_fifo_09_pull = r_pull_09;
    assign o_fifo_24_pull = r_pull_24;
    assign o_smi_read_req = r_read_req;
    assign o_active_ch    = r_active_ch;
    assign o_smi_data_out = r_data_out;

`ifdef SMI_RX_UNDERRUN_CNT_EN
    logic [7:0] r_underrun_cnt;

    // Count strobe ends that find no word in service, saturating at all-ones.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_underrun_cnt <= 8'h00;
        end else if (!i_enable) begin
            r_underrun_cnt <= 8'h00;
        end else if (w_strobe_end && (r_state != ST_SERVE) && (r_underrun_cnt != 8'hFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 8'h01;
        end
    end

    assign o_underrun_cnt = r_underrun_cnt;
`else
    assign o_underrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_smi_rx_scheduler.sv
// Self-checking bench for smi_rx_scheduler: directed scenarios followed by a
// randomized run, all compared against a queue-based model of the scheduler.
`timescale 1ns/1ps
module tb_smi_rx_scheduler;

    logic        clk = 1'b0;
    logic        rstB;
    logic        enable;
    logic [1:0]  mask;
    logic        pull09;
    logic        pull24;
    logic [31:0] data09 = 32'h0;
    logic [31:0] data24 = 32'h0;
    logic        empty09 = 1'b1;
    logic        empty24 = 1'b1;
    logic        soe;
    logic [7:0]  dataOut;
    logic        readReq;
    logic        activeCh;
    logic [7:0]  underCnt;

    logic [31:0] fifo09[$];
    logic [31:0] fifo24[$];
    logic [31:0] ref09[$];
    logic [31:0] ref24[$];

    int total = 0;
    int bad = 0;
    int lastServed = 1;
    int expUnder = 0;

    always #5 clk = ~clk;

    smi_rx_scheduler dut (
        .i_sys_clk             (clk),
        .i_rst_b               (rstB),
        .i_enable              (enable),
        .i_ch_mask             (mask),
        .o_fifo_09_pull        (pull09),
        .i_fifo_09_pulled_data (data09),
        .i_fifo_09_empty       (empty09),
        .o_fifo_24_pull        (pull24),
        .i_fifo_24_pulled_data (data24),
        .i_fifo_24_empty       (empty24),
        .i_smi_soe_se          (soe),
        .o_smi_data_out        (dataOut),
        .o_smi_read_req        (readReq),
        .o_active_ch           (activeCh),
        .o_underrun_cnt        (underCnt)
    );

    // FIFO stand-ins: a pull seen in a cycle presents the head word from that cycle on.
    always @(posedge clk) begin
        #2;
        if (pull09 && fifo09.size() > 0) data09 = fifo09.pop_front();
        if (pull24 && fifo24.size() > 0) data24 = fifo24.pop_front();
        empty09 = (fifo09.size() == 0);
        empty24 = (fifo24.size() == 0);
    end

    // Global time limit so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int expectedCnt();
`ifdef SMI_RX_UNDERRUN_CNT_EN
        return expUnder;
`else
        return 0;
`endif
    endfunction

    task automatic pushWord(input int ch, input logic [31:0] w);
        if (ch == 0) begin
            fifo09.push_back(w);
            ref09.push_back(w);
        end else begin
            fifo24.push_back(w);
            ref24.push_back(w);
        end
    endtask

    // Model of the arbitration rule: eligible = masked in and holding data,
    // a tie goes to whichever channel was not served last.
    function automatic int modelPick();
        bit e09 = mask[0] && (ref09.size() > 0);
        bit e24 = mask[1] && (ref24.size() > 0);
        int pick;
        if (e09 && e24) pick = (lastServed == 1) ? 0 : 1;
        else if (e09)   pick = 0;
        else if (e24)   pick = 1;
        else            pick = -1;
        if (pick >= 0) lastServed = pick;
        return pick;
    endfunction

    // One host read: strobe low for lo cycles, then high for hi cycles.
    task automatic driveStrobe(input int lo, input int hi);
        soe = 1'b0;
        repeat (lo) @(negedge clk);
        soe = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    // Random next-round setup: new words first, mask only once the FIFOs show them.
    task automatic applyStimulus(input bit lastRound);
        int n;
        logic [1:0] newMask;
        if (lastRound) begin
            mask = 2'b00;
            return;
        end
        newMask = 2'($urandom_range(1, 3));
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) pushWord($urandom_range(0, 1), $urandom);
        if (!((newMask[0] && ref09.size() > 0) || (newMask[1] && ref24.size() > 0)))
            pushWord(newMask[0] ? 0 : 1, $urandom);
        @(negedge clk);
        @(negedge clk);
        mask = newMask;
    endtask

    // Wait (bounded) for a pull strobe, check its channel, return the word it fetches.
    task automatic waitPull(input int ch, output logic [31:0] word);
        int n = 0;
        while (!(pull09 || pull24) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pullSeen", {31'h0, (pull09 || pull24)}, 32'h1);
        checkOutput("pullCh", {30'h0, pull24, pull09}, (ch == 0) ? 32'h1 : 32'h2);
        word = 32'h0;
        if (ch == 0 && ref09.size() > 0) word = ref09.pop_front();
        if (ch == 1 && ref24.size() > 0) word = ref24.pop_front();
    endtask

    // Serve a pulled word: request two cycles after the pull, bytes MSB first.
    task automatic serveBody(input int ch, input logic [31:0] word, input bit doNext, input bit lastRound);
        logic [7:0] expB;
        @(negedge clk);
        checkOutput("loadReq", {31'h0, readReq}, 32'h0);
        @(negedge clk);
        checkOutput("req", {31'h0, readReq}, 32'h1);
        checkOutput("activeCh", {31'h0, activeCh}, ch);
        for (int b = 0; b < 4; b++) begin
            expB = word[31-8*b -: 8];
            checkOutput($sformatf("byte%0d", b), {24'h0, dataOut}, {24'h0, expB});
            if (b == 3 && doNext) applyStimulus(lastRound);
            driveStrobe($urandom_range(1, 3), (b == 3) ? 3 : $urandom_range(3, 5));
        end
        checkOutput("endReq", {31'h0, readReq}, 32'h0);
        checkOutput("endData", {24'h0, dataOut}, 32'h0);
    endtask

    initial begin
        logic [31:0] w;
        int ch;
        int pulls;

        // Reset state
        rstB = 1'b0;
        enable = 1'b0;
        mask = 2'b00;
        soe = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstPull", {30'h0, pull24, pull09}, 32'h0);
        checkOutput("rstReq", {31'h0, readReq}, 32'h0);
        checkOutput("rstData", {24'h0, dataOut}, 32'h0);
        checkOutput("rstCh", {31'h0, activeCh}, 32'h0);
        checkOutput("rstCnt", {24'h0, underCnt}, 32'h0);
        rstB = 1'b1;

        // Single 0.9 GHz word, pull latency from enable
        pushWord(0, 32'hA1B2C3D4);
        mask = 2'b01;
        repeat (3) @(negedge clk);
        checkOutput("noPullDisabled", {30'h0, pull24, pull09}, 32'h0);
        enable = 1'b1;
        @(negedge clk);
        checkOutput("firstPull", {30'h0, pull24, pull09}, 32'h1);
        ch = modelPick();
        waitPull(ch, w);
        serveBody(ch, w, 1'b0, 1'b0);

        // Strobes with nothing staged
        mask = 2'b11;
        for (int i = 0; i < 305; i++) begin
            driveStrobe(1, 3);
            if (expUnder < 255) expUnder++;
            if (i < 5 || i == 304) begin
                checkOutput("underData", {24'h0, dataOut}, 32'h0);
                checkOutput("underReq", {31'h0, readReq}, 32'h0);
                checkOutput("underCnt", {24'h0, underCnt}, expectedCnt());
            end
        end

        // Disable after two bytes, then resume with a fresh word
        pushWord(1, 32'h11223344);
        pushWord(1, 32'h55667788);
        ch = modelPick();
        waitPull(ch, w);
        @(negedge clk);
        @(negedge clk);
        checkOutput("dropByte0", {24'h0, dataOut}, {24'h0, w[31:24]});
        driveStrobe(2, 3);
        driveStrobe(2, 3);
        checkOutput("dropByte2", {24'h0, dataOut}, {24'h0, w[15:8]});
        enable = 1'b0;
        expUnder = 0;
        @(negedge clk);
        checkOutput("dropReq", {31'h0, readReq}, 32'h0);
        checkOutput("dropData", {24'h0, dataOut}, 32'h0);
        checkOutput("dropCnt", {24'h0, underCnt}, expectedCnt());
        pulls = 0;
        repeat (20) begin
            @(negedge clk);
            if (pull09 || pull24) pulls++;
        end
        checkOutput("dropNoPull", pulls, 32'h0);
        enable = 1'b1;
        ch = modelPick();
        waitPull(ch, w);
        serveBody(ch, w, 1'b0, 1'b0);

        // Reset mid-serve, then tie-break restarts from the 0.9 GHz side
        mask = 2'b00;
        pushWord(0, 32'hCAFE0001);
        pushWord(0, 32'hCAFE0002);
        pushWord(1, 32'hBEEF0001);
        pushWord(1, 32'hBEEF0002);
        @(negedge clk);
        @(negedge clk);
        mask = 2'b11;
        ch = modelPick();
        waitPull(ch, w);
        @(negedge clk);
        @(negedge clk);
        driveStrobe(1, 3);
        checkOutput("midByte1", {24'h0, dataOut}, {24'h0, w[23:16]});
        rstB = 1'b0;
        #1;
        checkOutput("midRstReq", {31'h0, readReq}, 32'h0);
        checkOutput("midRstData", {24'h0, dataOut}, 32'h0);
        checkOutput("midRstCh", {31'h0, activeCh}, 32'h0);
        checkOutput("midRstPull", {30'h0, pull24, pull09}, 32'h0);
        expUnder = 0;
        lastServed = 1;
        repeat (3) @(negedge clk);
        rstB = 1'b1;
        ch = modelPick();
        checkOutput("tieAfterRst", ch, 32'h0);
        waitPull(ch, w);
        serveBody(ch, w, 1'b0, 1'b0);
        while (ref09.size() + ref24.size() > 0) begin
            ch = modelPick();
            waitPull(ch, w);
            serveBody(ch, w, 1'b0, 1'b0);
        end

        // Mask 00 blocks all pulls even with data waiting
        mask = 2'b00;
        pushWord(0, $urandom);
        pushWord(1, $urandom);
        pulls = 0;
        repeat (1000) begin
            @(negedge clk);
            if (pull09 || pull24) pulls++;
        end
        checkOutput("maskZeroPulls", pulls, 32'h0);

        // Randomized words against the model
        applyStimulus(1'b0);
        for (int i = 0; i < 30; i++) begin
            ch = modelPick();
            waitPull(ch, w);
            serveBody(ch, w, 1'b1, i == 29);
        end
        checkOutput("finalCnt", {24'h0, underCnt}, expectedCnt());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
